addr_seq: RTL and testbench
===========================

Name: addr_seq

Overview:
Registered program-counter and address sequencer, the parametrised successor to the combinational address mux. It holds the PC in a register and generates the memory address each cycle. It supports sequential fetch, jumps, call/return through an internal return-address stack, and data-memory accesses that leave the PC unchanged. It sits between the decoder/ALU and the unified instruction/data memory port.

Parameters:
MEM_DEPTH, 4096, memory depth in words.
WORD_BYTES, 2, bytes per word. This is also the sequential PC increment. Power of two, ≥1.
STACK_DEPTH, 8, return-stack entries. Power of two, ≥2.
RESET_PC, 0, PC value after reset. Must be WORD_BYTES-aligned.
(localparam) ADDR_WIDTH = $clog2(MEM_DEPTH*WORD_BYTES), byte-address width.
(localparam) ALIGN_BITS = $clog2(WORD_BYTES).

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
i_en  in  1  request to execute i_mode this cycle
i_mem_ready  in  1  memory accepts the access this cycle
i_mode  in  3  0 NORMAL, 1 JUMP, 2 CALL, 3 RET, 4 DATA, 5 HOLD; 6/7 are treated as HOLD
i_alu_addr  in  32  jump/call target or data address from the ALU
o_addr  out  ADDR_WIDTH  byte address to memory
o_pc  out  ADDR_WIDTH  current PC register
o_data_sel  out  1  1 when o_addr is a data address (DATA mode)
o_misalign  out  1  one-cycle pulse: a taken target had non-zero low bits
o_stack_ovf  out  1  sticky: CALL attempted with stack full
o_stack_unf  out  1  sticky: RET attempted with stack empty
o_stack_cnt  out  $clog2(STACK_DEPTH+1)  occupied stack entries

Behaviour:
- Reset:
  - rst_n=0 at a clock edge sets: pc=RESET_PC, stack count=0, o_misalign=0, o_stack_ovf=0, o_stack_unf=0.
  - Stack entry contents are don't-care.
  - Reset overrides any in-flight step; no partial push or pop survives.
- Step:
  - A step occurs when i_en=1 and i_mem_ready=1.
  - With no step, pc, stack and sticky flags hold, and o_misalign is 0 next cycle.
- Combinational address:
  - o_addr = i_alu_addr[ADDR_WIDTH-1:0] when i_mode=DATA; otherwise o_addr = pc.
  - o_data_sel = (i_mode==DATA), independent of i_en.
  - o_pc = pc.
- Target alignment:
  - tgt = i_alu_addr[ADDR_WIDTH-1:0] with its ALIGN_BITS LSBs forced to 0.
  - Upper bits of i_alu_addr beyond ADDR_WIDTH are ignored.
- Per-mode effect on a step (takes effect next cycle):
  - NORMAL: pc <= pc + WORD_BYTES, modulo 2^ADDR_WIDTH. The top address wraps to 0 silently.
  - JUMP: pc <= tgt. o_misalign <= 1 if the ALIGN_BITS LSBs of i_alu_addr were non-zero.
  - CALL, stack not full: push (pc + WORD_BYTES) mod 2^ADDR_WIDTH; cnt+1; pc <= tgt; misalign as for JUMP.
  - CALL, stack full: no push, pc holds, o_stack_ovf <= 1 (sticky until reset).
  - RET, stack not empty: pc <= top entry; cnt-1.
  - RET, stack empty: pc holds, o_stack_unf <= 1 (sticky).
  - DATA: pc and stack hold. The access completes in this cycle.
  - HOLD / 6 / 7: no state change.
- Latency:
  - A jump, call or return target appears on o_addr/o_pc one cycle after the step.
  - A data address appears on o_addr in the same cycle.
- o_misalign is registered, high for exactly one cycle after the offending step.
- A stall (i_mem_ready=0) with any mode leaves all state untouched. The request is retried by holding the inputs.

Decomposition:
- Shared package addr_pkg holds:
  - the mode enum addr_mode_e (3 bits) with the values above;
  - the localparam functions for ADDR_WIDTH and ALIGN_BITS.
- Sub-module ret_stack(DEPTH, WIDTH): a LIFO with push, pop, full, empty, cnt and top.
  - push and pop are never asserted together by addr_seq.
  - It has its own synchronous active-low reset.

Test Plan:
- Reset: hold rst_n=0 with RESET_PC=0x10 -> pc=0x10, cnt=0, all flags 0. Then NORMAL ×3 steps -> o_pc 0x12, 0x14, 0x16.
- Wrap: force pc to 0x1FFE (ADDR_WIDTH=13), NORMAL step -> pc=0x0000, no flag.
- Call/return: at pc=0x100, CALL with alu=0x0345 -> pc=0x344, o_misalign pulses 1 cycle, cnt=1. Then RET -> pc=0x102, cnt=0.
- Overflow/underflow:
  - 8 CALLs then a 9th -> pc unchanged after the 9th, o_stack_ovf=1, cnt=8.
  - Reset, then RET -> o_stack_unf=1, pc unchanged.
- Data/stall: at pc=0x40, DATA with alu=0x0ABC -> o_addr=0xABC and o_data_sel=1 in the same cycle, pc stays 0x40. Then NORMAL with i_mem_ready=0 for 3 cycles -> pc stays 0x40, and advances to 0x42 on the first ready cycle.
- Reset mid-call: assert rst_n=0 in the same cycle as a CALL step -> pc=RESET_PC, cnt=0, no push observed.

Source files
------------

// File: rtl/addr_pkg.sv
// Shared definitions for the address sequencer: access modes and the
// width helpers used to size its address and alignment fields.
package addr_pkg;

    typedef enum logic [2:0] {
        MODE_NORMAL = 3'd0,
        MODE_JUMP   = 3'd1,
        MODE_CALL   = 3'd2,
        MODE_RET    = 3'd3,
        MODE_DATA   = 3'd4,
        MODE_HOLD   = 3'd5
    } addr_mode_e;

    function automatic int addr_width_f(input int mem_depth, input int word_bytes);
        return $clog2(mem_depth * word_bytes);
    endfunction

    function automatic int align_bits_f(input int word_bytes);
        return $clog2(word_bytes);
    endfunction

endpackage

// File: rtl/addr_seq_ret_stack.sv
// Return-address LIFO. Entries are never cleared; only the occupancy count
// is reset, so stale contents are simply unreachable.
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 13,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_cnt
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == CNT_W'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_cnt     = r_cnt;
    assign w_wr_idx  = r_cnt[IDX_W-1:0];
    assign w_rd_idx  = IDX_W'(r_cnt - CNT_W'(1));
    assign o_top     = r_mem[w_rd_idx];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_do_push) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_do_pop) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Write is suppressed under reset so a colliding push leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n && w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/addr_seq.sv
// Registered PC and address sequencer: sequential fetch, jumps, call/return
// via an internal return stack, and same-cycle data-address pass-through.
module addr_seq
    import addr_pkg::*;
#(
    parameter int MEM_DEPTH   = 4096,
    parameter int WORD_BYTES  = 2,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0,
    localparam int ADDR_WIDTH = addr_width_f(MEM_DEPTH, WORD_BYTES),
    localparam int ALIGN_BITS = align_bits_f(WORD_BYTES),
    localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_mem_ready,
    input  logic [2:0]            i_mode,
    input  logic [31:0]           i_alu_addr,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_data_sel,
    output logic                  o_misalign,
    output logic                  o_stack_ovf,
    output logic                  o_stack_unf,
    output logic [CNT_W-1:0]      o_stack_cnt
);

    // Low-bit mask built by shifting so a one-byte word gives an empty mask.
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << ALIGN_BITS) - 1);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_misalign;
    logic                  r_ovf;
    logic                  r_unf;

    logic [ADDR_WIDTH-1:0] w_alu;
    logic [ADDR_WIDTH-1:0] w_tgt;
    logic [ADDR_WIDTH-1:0] w_seq;
    logic [ADDR_WIDTH-1:0] w_top;
    logic                  w_mis;
    logic                  w_step;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

    assign w_alu  = i_alu_addr[ADDR_WIDTH-1:0];
    assign w_tgt  = w_alu & ~LOW_MASK;
    assign w_mis  = |(w_alu & LOW_MASK);
    assign w_seq  = r_pc + ADDR_WIDTH'(WORD_BYTES);
    assign w_step = i_en && i_mem_ready;
    assign w_push = w_step && (i_mode == MODE_CALL) && !w_full;
    assign w_pop  = w_step && (i_mode == MODE_RET) && !w_empty;

    assign o_data_sel  = (i_mode == MODE_DATA);
    assign o_addr      = o_data_sel ? w_alu : r_pc;
    assign o_pc        = r_pc;
    assign o_misalign  = r_misalign;
    assign o_stack_ovf = r_ovf;
    assign o_stack_unf = r_unf;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_seq),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (o_stack_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= ADDR_WIDTH'(RESET_PC);
            r_misalign <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (w_step) begin
                case (i_mode)
                    MODE_NORMAL: r_pc <= w_seq;
                    MODE_JUMP: begin
                        r_pc       <= w_tgt;
                        r_misalign <= w_mis;
                    end
                    MODE_CALL: begin
                        if (!w_full) begin
                            r_pc       <= w_tgt;
                            r_misalign <= w_mis;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                    MODE_RET: begin
                        if (!w_empty) begin
                            r_pc <= w_top;
                        end else begin
                            r_unf <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_addr_seq.sv
// Randomised bench for addr_seq against a queue-based behavioural model.
module tb_addr_seq;

    localparam int AW     = 13;
    localparam int WB     = 2;
    localparam int SDEPTH = 8;
    localparam int RPC    = 'h10;
    localparam int AMOD   = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_en;
    logic          i_mem_ready;
    logic [2:0]    i_mode;
    logic [31:0]   i_alu_addr;
    logic [AW-1:0] o_addr;
    logic [AW-1:0] o_pc;
    logic          o_data_sel;
    logic          o_misalign;
    logic          o_stack_ovf;
    logic          o_stack_unf;
    logic [3:0]    o_stack_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int m_pc;
    int m_stk[$];
    bit m_mis, m_ovf, m_unf;
    bit m_known = 0;

    always #5 clk = ~clk;

    addr_seq #(
        .MEM_DEPTH   (4096),
        .WORD_BYTES  (WB),
        .STACK_DEPTH (SDEPTH),
        .RESET_PC    (RPC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (i_en),
        .i_mem_ready (i_mem_ready),
        .i_mode      (i_mode),
        .i_alu_addr  (i_alu_addr),
        .o_addr      (o_addr),
        .o_pc        (o_pc),
        .o_data_sel  (o_data_sel),
        .o_misalign  (o_misalign),
        .o_stack_ovf (o_stack_ovf),
        .o_stack_unf (o_stack_unf),
        .o_stack_cnt (o_stack_cnt)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural effect of one clock edge, from the mode rules.
    task automatic model_edge();
        int tgt;
        int lo;
        tgt = int'(i_alu_addr % AMOD) & ~(WB - 1);
        lo  = int'(i_alu_addr % WB);
        if (!rst_n) begin
            m_pc = RPC;
            m_stk.delete();
            m_mis = 0; m_ovf = 0; m_unf = 0;
            m_known = 1;
            return;
        end
        m_mis = 0;
        if (!(i_en && i_mem_ready)) return;
        case (i_mode)
            3'd0: m_pc = (m_pc + WB) % AMOD;
            3'd1: begin m_pc = tgt; m_mis = (lo != 0); end
            3'd2: begin
                if (m_stk.size() < SDEPTH) begin
                    m_stk.push_back((m_pc + WB) % AMOD);
                    m_pc  = tgt;
                    m_mis = (lo != 0);
                end else begin
                    m_ovf = 1;
                end
            end
            3'd3: begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else m_unf = 1;
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        int exp_addr;
        if (!m_known) return;
        exp_addr = (i_mode == 3'd4) ? int'(i_alu_addr % AMOD) : m_pc;
        chk("pc",       o_pc,        m_pc);
        chk("addr",     o_addr,      exp_addr);
        chk("data_sel", o_data_sel,  (i_mode == 3'd4));
        chk("misalign", o_misalign,  m_mis);
        chk("ovf",      o_stack_ovf, m_ovf);
        chk("unf",      o_stack_unf, m_unf);
        chk("cnt",      o_stack_cnt, m_stk.size());
    endtask

    // Apply inputs just after the edge, sample mid-cycle, then advance.
    task automatic cyc(input bit rn, input bit en, input bit rdy, input int mode, input int alu);
        rst_n       = rn;
        i_en        = en;
        i_mem_ready = rdy;
        i_mode      = 3'(mode);
        i_alu_addr  = alu;
        #2;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; i_en = 1'b0; i_mem_ready = 1'b1; i_mode = 3'd5; i_alu_addr = '0;
        @(posedge clk);
        #1;

        cyc(0, 0, 1, 5, 0);
        cyc(0, 1, 1, 2, 'h300);
        chk("reset_pc", o_pc, RPC);
        repeat (3) cyc(1, 1, 1, 0, 0);
        chk("normal_x3", o_pc, 'h16);

        cyc(1, 1, 1, 1, 'h1FFE);
        chk("pre_wrap", o_pc, 'h1FFE);
        cyc(1, 1, 1, 0, 0);
        chk("wrap", o_pc, 0);

        cyc(1, 1, 1, 1, 'h100);
        cyc(1, 1, 1, 2, 'h0345);
        chk("call_pc", o_pc, 'h344);
        chk("call_mis", o_misalign, 1);
        cyc(1, 1, 1, 3, 0);
        chk("ret_pc", o_pc, 'h102);
        chk("ret_cnt", o_stack_cnt, 0);

        for (int i = 0; i < 9; i++) cyc(1, 1, 1, 2, 'h200 + i * 4);
        chk("ovf_flag", o_stack_ovf, 1);
        chk("ovf_cnt", o_stack_cnt, 8);
        chk("ovf_pc", o_pc, 'h21C);
        cyc(0, 0, 1, 5, 0);
        cyc(1, 1, 1, 3, 0);
        chk("unf_flag", o_stack_unf, 1);
        chk("unf_pc", o_pc, RPC);

        cyc(1, 1, 1, 1, 'h40);
        cyc(1, 1, 1, 4, 'h0ABC);
        chk("data_pc", o_pc, 'h40);
        repeat (3) cyc(1, 1, 0, 0, 0);
        chk("stall_pc", o_pc, 'h40);
        cyc(1, 1, 1, 0, 0);
        chk("resume_pc", o_pc, 'h42);

        cyc(1, 1, 1, 2, 'h500);
        cyc(0, 1, 1, 2, 'h600);
        chk("rst_call_pc", o_pc, RPC);
        chk("rst_call_cnt", o_stack_cnt, 0);

        for (int i = 0; i < 2000; i++) begin
            int mode;
            int alu;
            mode = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) mode = $urandom_range(2, 3);
            alu = int'($urandom());
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 4) != 0), mode, alu);
        end
        cyc(1, 0, 1, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
